ml_accel_seq: RTL and testbench

Job sequencer in front of the `ml_accel` dot-product coprocessor. It accepts dot-product job descriptors (two source vector addresses, one destination address) into a small queue. For each job it fetches eight operand words from data memory, programs them into the accelerator's register window, starts it, waits for `done`, and writes the 32-bit result back to memory. This offloads the CPU from the 10-access programming sequence per dot product.

---
 rtl/ml_accel_pkg.sv | 23 ++
 rtl/ml_job_fifo.sv | 57 +++++
 rtl/ml_accel_seq.sv | 186 ++++++++++++++++++
 tb/tb_ml_accel_seq.sv | 262 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/ml_accel_pkg.sv
// Shared definitions for the ml_accel job sequencer: accelerator register map,
// FSM state encoding and descriptor sizing.
package ml_accel_pkg;

   localparam logic [5:0] ACC_A0     = 6'h00;
   localparam logic [5:0] ACC_B0     = 6'h10;
   localparam logic [5:0] ACC_CTRL   = 6'h20;
   localparam logic [5:0] ACC_RESULT = 6'h24;

   typedef enum logic [2:0] {
      ST_IDLE  = 3'd0,
      ST_LOAD  = 3'd1,
      ST_START = 3'd2,
      ST_WAIT  = 3'd3,
      ST_WB    = 3'd4
   } state_e;

   // A descriptor packs {src_a, src_b, dst}.
   function automatic int desc_w(input int aw);
      return 3 * aw;
   endfunction

endpackage

// File: rtl/ml_job_fifo.sv
// Job descriptor queue: synchronous FIFO with registered full/empty flags.
module ml_job_fifo #(
   parameter int W     = 96,
   parameter int DEPTH = 4
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         wr_en,
   input  logic [W-1:0] wr_data,
   output logic         full,
   input  logic         rd_en,
   output logic [W-1:0] rd_data,
   output logic         empty
);

   localparam int PW = $clog2(DEPTH);

   logic [W-1:0] mem_q [DEPTH];
   logic [PW:0]  wptr_q, wptr_d, rptr_q, rptr_d;
   logic         full_q, full_d, empty_q, empty_d;
   logic         do_wr_s, do_rd_s;

   always_comb begin
      do_wr_s = wr_en && !full_q;
      do_rd_s = rd_en && !empty_q;
      wptr_d  = do_wr_s ? wptr_q + {{PW{1'b0}}, 1'b1} : wptr_q;
      rptr_d  = do_rd_s ? rptr_q + {{PW{1'b0}}, 1'b1} : rptr_q;
      // Extra pointer MSB distinguishes full from empty when indices match.
      empty_d = (wptr_d == rptr_d);
      full_d  = (wptr_d[PW] != rptr_d[PW]) && (wptr_d[PW-1:0] == rptr_d[PW-1:0]);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wptr_q  <= '0;
         rptr_q  <= '0;
         full_q  <= 1'b0;
         empty_q <= 1'b1;
      end else begin
         wptr_q  <= wptr_d;
         rptr_q  <= rptr_d;
         full_q  <= full_d;
         empty_q <= empty_d;
      end
   end

   always_ff @(posedge clk) begin
      if (do_wr_s) begin
         mem_q[wptr_q[PW-1:0]] <= wr_data;
      end
   end

   assign rd_data = mem_q[rptr_q[PW-1:0]];
   assign full    = full_q;
   assign empty   = empty_q;

endmodule

// File: rtl/ml_accel_seq.sv
// Job sequencer for the ml_accel dot-product coprocessor: fetches operands,
// programs and starts the accelerator, and writes the result back to memory.
module ml_accel_seq
   import ml_accel_pkg::*;
#(
   parameter int AW      = 32,
   parameter int QDEPTH  = 4,
   parameter int TIMEOUT = 16
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic          job_valid,
   output logic          job_ready,
   input  logic [AW-1:0] job_src_a,
   input  logic [AW-1:0] job_src_b,
   input  logic [AW-1:0] job_dst,
   output logic          mem_req,
   output logic          mem_we,
   output logic [AW-1:0] mem_addr,
   output logic [31:0]   mem_wdata,
   input  logic [31:0]   mem_rdata,
   output logic          acc_w_en,
   output logic          acc_r_en,
   output logic [5:0]    acc_addr,
   output logic [31:0]   acc_w_data,
   input  logic [31:0]   acc_r_data,
   input  logic          acc_done,
   output logic          busy,
   output logic          job_done,
   output logic          err,
   input  logic          err_clr,
   output logic [15:0]   jobs_cnt
);

   localparam int DW = desc_w(AW);
   localparam int TW = $clog2(TIMEOUT + 1);

   state_e        state_q, state_d;
   logic [3:0]    k_q, k_d;
   logic [TW-1:0] wcnt_q, wcnt_d;
   logic [AW-1:0] src_a_q, src_a_d, src_b_q, src_b_d, dst_q, dst_d;
   logic          err_q, err_d;
   logic [15:0]   jobs_cnt_q, jobs_cnt_d;
   logic          fifo_full_s, fifo_empty_s, pop_s;
   logic [DW-1:0] fifo_dout_s;
   logic [2:0]    km1_s;

   ml_job_fifo #(.W(DW), .DEPTH(QDEPTH)) u_fifo (
      .clk     (clk),
      .rst_n   (rst_n),
      .wr_en   (job_valid),
      .wr_data ({job_src_a, job_src_b, job_dst}),
      .full    (fifo_full_s),
      .rd_en   (pop_s),
      .rd_data (fifo_dout_s),
      .empty   (fifo_empty_s)
   );

   always_comb begin
      state_d    = state_q;
      k_d        = k_q;
      wcnt_d     = wcnt_q;
      src_a_d    = src_a_q;
      src_b_d    = src_b_q;
      dst_d      = dst_q;
      jobs_cnt_d = jobs_cnt_q;
      pop_s      = 1'b0;
      err_d      = err_clr ? 1'b0 : err_q;
      case (state_q)
         ST_IDLE: begin
            if (!fifo_empty_s) begin
               pop_s                      = 1'b1;
               {src_a_d, src_b_d, dst_d}  = fifo_dout_s;
               k_d                        = 4'd0;
               state_d                    = ST_LOAD;
            end else begin
               state_d = ST_IDLE;
            end
         end
         ST_LOAD: begin
            if (k_q == 4'd8) begin
               state_d = ST_START;
            end else begin
               k_d = k_q + 4'd1;
            end
         end
         ST_START: begin
            wcnt_d  = '0;
            state_d = ST_WAIT;
         end
         ST_WAIT: begin
            // A timeout set wins over a simultaneous err_clr.
            if (acc_done) begin
               state_d = ST_WB;
            end else if (wcnt_q == TW'(TIMEOUT - 1)) begin
               err_d   = 1'b1;
               state_d = ST_IDLE;
            end else begin
               wcnt_d = wcnt_q + TW'(1);
            end
         end
         ST_WB: begin
            jobs_cnt_d = jobs_cnt_q + 16'd1;
            state_d    = ST_IDLE;
         end
         default: state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q    <= ST_IDLE;
         k_q        <= 4'd0;
         wcnt_q     <= '0;
         src_a_q    <= '0;
         src_b_q    <= '0;
         dst_q      <= '0;
         err_q      <= 1'b0;
         jobs_cnt_q <= 16'd0;
      end else begin
         state_q    <= state_d;
         k_q        <= k_d;
         wcnt_q     <= wcnt_d;
         src_a_q    <= src_a_d;
         src_b_q    <= src_b_d;
         dst_q      <= dst_d;
         err_q      <= err_d;
         jobs_cnt_q <= jobs_cnt_d;
      end
   end

   // Bus strobes decode purely from state flops, so reset drops them at once.
   always_comb begin
      mem_req    = 1'b0;
      mem_we     = 1'b0;
      mem_addr   = '0;
      mem_wdata  = 32'd0;
      acc_w_en   = 1'b0;
      acc_r_en   = 1'b0;
      acc_addr   = 6'd0;
      acc_w_data = 32'd0;
      job_done   = 1'b0;
      km1_s      = k_q[2:0] - 3'd1;
      case (state_q)
         ST_LOAD: begin
            if (!k_q[3]) begin
               mem_req  = 1'b1;
               mem_addr = (k_q[2] ? src_b_q : src_a_q) + AW'({k_q[1:0], 2'b00});
            end else begin
               mem_req  = 1'b0;
               mem_addr = '0;
            end
            if (k_q != 4'd0) begin
               acc_w_en   = 1'b1;
               acc_addr   = (km1_s[2] ? ACC_B0 : ACC_A0) + {2'b00, km1_s[1:0], 2'b00};
               acc_w_data = mem_rdata;
            end else begin
               acc_w_en   = 1'b0;
               acc_addr   = 6'd0;
               acc_w_data = 32'd0;
            end
         end
         ST_START: begin
            acc_w_en   = 1'b1;
            acc_addr   = ACC_CTRL;
            acc_w_data = 32'd1;
         end
         ST_WB: begin
            acc_r_en  = 1'b1;
            acc_addr  = ACC_RESULT;
            mem_req   = 1'b1;
            mem_we    = 1'b1;
            mem_addr  = dst_q;
            mem_wdata = acc_r_data;
            job_done  = 1'b1;
         end
         default: job_done = 1'b0;
      endcase
   end

   assign job_ready = !fifo_full_s;
   assign busy      = (state_q != ST_IDLE) || !fifo_empty_s;
   assign err       = err_q;
   assign jobs_cnt  = jobs_cnt_q;

endmodule

// File: tb/tb_ml_accel_seq.sv
// Directed bench for ml_accel_seq with a one-cycle-latency memory model and a
// dot-product accelerator model.
module tb_ml_accel_seq;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        job_valid, job_ready;
   logic [31:0] job_src_a, job_src_b, job_dst;
   logic        mem_req, mem_we;
   logic [31:0] mem_addr, mem_wdata, mem_rdata;
   logic        acc_w_en, acc_r_en;
   logic [5:0]  acc_addr;
   logic [31:0] acc_w_data, acc_r_data;
   logic        acc_done;
   logic        busy, job_done, err, err_clr;
   logic [15:0] jobs_cnt;

   int n_tests = 0;
   int n_fail  = 0;
   int cyc     = 0;

   logic [31:0] mem [0:255];
   int          wr_cnt = 0;
   logic [31:0] wr_addr_log [0:31];
   logic [31:0] wr_data_log [0:31];
   int          jd_cnt = 0;
   int          jd_cyc [0:31];

   logic [31:0] acc_regs [0:7];
   logic [31:0] acc_res  = 32'd0;
   logic        acc_pend = 1'b0;
   logic        acc_hang;
   logic [31:0] dot_s;

   ml_accel_seq dut (
      .clk(clk), .rst_n(rst_n),
      .job_valid(job_valid), .job_ready(job_ready),
      .job_src_a(job_src_a), .job_src_b(job_src_b), .job_dst(job_dst),
      .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
      .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
      .acc_w_en(acc_w_en), .acc_r_en(acc_r_en), .acc_addr(acc_addr),
      .acc_w_data(acc_w_data), .acc_r_data(acc_r_data), .acc_done(acc_done),
      .busy(busy), .job_done(job_done), .err(err), .err_clr(err_clr),
      .jobs_cnt(jobs_cnt)
   );

   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   // Memory: read data one cycle after the request; writes are logged.
   always @(posedge clk) begin
      if (mem_req && !mem_we) mem_rdata <= mem[mem_addr[9:2]];
      if (mem_req && mem_we) begin
         mem[mem_addr[9:2]]  <= mem_wdata;
         wr_addr_log[wr_cnt] <= mem_addr;
         wr_data_log[wr_cnt] <= mem_wdata;
         wr_cnt              <= wr_cnt + 1;
      end
   end

   always @(posedge clk) begin
      if (job_done) begin
         jd_cyc[jd_cnt] <= cyc;
         jd_cnt         <= jd_cnt + 1;
      end
   end

   always_comb begin
      dot_s = 32'd0;
      for (int i = 0; i < 4; i++) dot_s = dot_s + acc_regs[i] * acc_regs[i+4];
   end

   // Accelerator: done two cycles after the CTRL start write, unless hung.
   always @(posedge clk) begin
      acc_done <= 1'b0;
      if (acc_w_en && acc_addr == 6'h20) begin
         acc_res  <= dot_s;
         acc_pend <= !acc_hang;
      end else if (acc_w_en) begin
         acc_regs[acc_addr[4:2]] <= acc_w_data;
      end else if (acc_pend) begin
         acc_done <= 1'b1;
         acc_pend <= 1'b0;
      end
   end

   assign acc_r_data = (acc_r_en && acc_addr == 6'h24) ? acc_res : 32'd0;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_tests++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   task automatic wait_done(input int target, input int budget);
      int i = 0;
      while (jd_cnt < target && i < budget) begin
         @(negedge clk);
         i++;
      end
      n_tests++;
      assert (jd_cnt >= target) else begin
         n_fail++;
         $error("FAIL wait_done: observed %0d jobs expected %0d", jd_cnt, target);
      end
   endtask

   task automatic push(input logic [31:0] a, input logic [31:0] b, input logic [31:0] d);
      job_valid = 1'b1;
      job_src_a = a;
      job_src_b = b;
      job_dst   = d;
      @(negedge clk);
      job_valid = 1'b0;
   endtask

   int p, q, t, r;

   initial begin
      rst_n = 1'b0; job_valid = 1'b0; job_src_a = 32'd0; job_src_b = 32'd0;
      job_dst = 32'd0; err_clr = 1'b0; acc_hang = 1'b0; acc_done = 1'b0;
      mem_rdata = 32'd0;
      for (int i = 0; i < 256; i++) mem[i] = 32'd0;
      for (int i = 0; i < 8; i++) acc_regs[i] = 32'd0;
      for (int i = 0; i < 4; i++) begin
         mem[i]      = 32'(i + 1);
         mem[4 + i]  = 32'(i + 5);
         mem[32 + i] = 32'hFFFF_FFFF;
         mem[36 + i] = 32'd2;
      end

      repeat (2) @(negedge clk);
      check("rst_job_ready", job_ready, 32'd1);
      check("rst_busy", busy, 32'd0);
      check("rst_mem_req", mem_req, 32'd0);
      check("rst_acc_w_en", acc_w_en, 32'd0);
      check("rst_jobs_cnt", jobs_cnt, 32'd0);
      check("rst_err", err, 32'd0);
      rst_n = 1'b1;
      repeat (2) @(negedge clk);

      // Basic job: 1*5+2*6+3*7+4*8 = 70
      p = cyc;
      push(32'h00, 32'h10, 32'h40);
      @(negedge clk);
      check("ld_k0_req", mem_req, 32'd1);
      check("ld_k0_addr", mem_addr, 32'h00);
      @(negedge clk);
      check("ld_k1_wen", acc_w_en, 32'd1);
      check("ld_k1_accaddr", acc_addr, 32'h00);
      check("ld_k1_wdata", acc_w_data, 32'd1);
      check("ld_k1_addr", mem_addr, 32'h04);
      repeat (8) @(negedge clk);
      check("start_wen", acc_w_en, 32'd1);
      check("start_addr", acc_addr, 32'h20);
      check("start_data", acc_w_data, 32'd1);
      check("start_mem_req", mem_req, 32'd0);
      wait_done(1, 40);
      check("basic_done_cyc", jd_cyc[0], p + 14);
      check("basic_wr_cnt", wr_cnt, 32'd1);
      check("basic_wr_addr", wr_addr_log[0], 32'h40);
      check("basic_wr_data", wr_data_log[0], 32'd70);
      check("basic_jobs_cnt", jobs_cnt, 32'd1);
      repeat (5) @(negedge clk);
      check("basic_single_pulse", jd_cnt, 32'd1);
      check("basic_idle", busy, 32'd0);

      // Truncation: 4 * (0xFFFFFFFF * 2) mod 2^32
      push(32'h80, 32'h90, 32'h44);
      wait_done(2, 40);
      check("trunc_wr_data", wr_data_log[1], 32'hFFFF_FFF8);
      check("trunc_wr_addr", wr_addr_log[1], 32'h44);
      check("trunc_jobs_cnt", jobs_cnt, 32'd2);

      // Queue full: five back-to-back pushes; the first is popped right away
      repeat (3) @(negedge clk);
      q = cyc;
      for (int i = 0; i < 5; i++) begin
         check("qf_ready_before_push", job_ready, 32'd1);
         job_valid = 1'b1;
         job_src_a = 32'h00;
         job_src_b = 32'h10;
         job_dst   = 32'h100 + 32'(4 * i);
         @(negedge clk);
      end
      job_valid = 1'b0;
      check("qf_ready_low", job_ready, 32'd0);
      check("qf_busy", busy, 32'd1);
      wait_done(7, 120);
      check("qf_first_done", jd_cyc[2], q + 14);
      for (int i = 0; i < 4; i++) check("qf_spacing", jd_cyc[3 + i] - jd_cyc[2 + i], 32'd14);
      for (int i = 0; i < 5; i++) check("qf_order", wr_addr_log[2 + i], 32'h100 + 32'(4 * i));
      check("qf_data_last", wr_data_log[6], 32'd70);
      check("qf_ready_back", job_ready, 32'd1);
      check("qf_jobs_cnt", jobs_cnt, 32'd7);

      // Timeout on job X, then job Y runs normally
      repeat (3) @(negedge clk);
      acc_hang = 1'b1;
      t = cyc;
      push(32'h00, 32'h10, 32'h200);
      push(32'h00, 32'h10, 32'h204);
      repeat (10) @(negedge clk);
      acc_hang = 1'b0;
      repeat (15) @(negedge clk);
      check("to_cycle_now", cyc, t + 27);
      check("to_err_before", err, 32'd0);
      check("to_no_write", wr_cnt, 32'd7);
      @(negedge clk);
      check("to_err_set", err, 32'd1);
      check("to_no_done", jd_cnt, 32'd7);
      check("to_next_queued", busy, 32'd1);
      wait_done(8, 40);
      check("to_next_addr", wr_addr_log[7], 32'h204);
      check("to_next_data", wr_data_log[7], 32'd70);
      check("to_err_sticky", err, 32'd1);
      err_clr = 1'b1;
      @(negedge clk);
      err_clr = 1'b0;
      check("to_err_clr", err, 32'd0);

      // Counter wrap from 0xFFFF
      force dut.jobs_cnt_d = 16'hFFFF;
      @(negedge clk);
      release dut.jobs_cnt_d;
      check("wrap_preload", jobs_cnt, 32'hFFFF);
      push(32'h00, 32'h10, 32'h48);
      wait_done(9, 40);
      check("wrap_zero", jobs_cnt, 32'd0);

      // Reset during LOAD k=5 with another job still queued
      repeat (3) @(negedge clk);
      r = cyc;
      push(32'h00, 32'h10, 32'h300);
      push(32'h00, 32'h10, 32'h304);
      repeat (5) @(negedge clk);
      check("rl_cycle_now", cyc, r + 7);
      check("rl_req_before", mem_req, 32'd1);
      check("rl_addr_before", mem_addr, 32'h14);
      #1 rst_n = 1'b0;
      #1;
      check("rl_mem_req", mem_req, 32'd0);
      check("rl_acc_w_en", acc_w_en, 32'd0);
      check("rl_busy", busy, 32'd0);
      check("rl_ready", job_ready, 32'd1);
      check("rl_jobs_cnt", jobs_cnt, 32'd0);
      @(negedge clk);
      rst_n = 1'b1;
      repeat (30) @(negedge clk);
      check("rl_no_write", wr_cnt, 32'd9);
      check("rl_no_done", jd_cnt, 32'd9);
      check("rl_idle", busy, 32'd0);
      check("rl_cnt_after", jobs_cnt, 32'd0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
